// File: rtl/mux_rr_pipe_pkg.sv
// mux_rr_pipe_pkg
// Shared definitions for the registered N-channel operand multiplexer:
//   - clog2():      ceiling log2, sizes the channel-index / select fields
//   - MODE_FIXED:   Mode value selecting the channel given by Sel
//   - MODE_RR:      Mode value selecting round-robin arbitration
//   - out_state_e:  occupancy state of the single output register
package mux_rr_pipe_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pipe_if.sv
// mux_rr_pipe_if
// Handshake bundle between the channel producers / consumer and mux_rr_pipe.
//   Mode, Sel             : selection control
//   In_Data, In_Valid     : packed per-channel words and valids (channel k at [k*WIDTH +: WIDTH])
//   In_Ready              : per-channel ready from the mux (one-hot or zero)
//   Out_Data, Out_Chan    : registered selected word and its source channel
//   Out_Valid, Out_Ready  : output handshake
// Modports: master = environment side, slave = mux side.
interface mux_rr_pipe_if #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned CHANNELS = 4
);
    import mux_rr_pipe_pkg::*;

    localparam int unsigned SEL_W = clog2(CHANNELS);

    logic                      Mode;
    logic [SEL_W-1:0]          Sel;
    logic [CHANNELS*WIDTH-1:0] In_Data;
    logic [CHANNELS-1:0]       In_Valid;
    logic [CHANNELS-1:0]       In_Ready;
    logic [WIDTH-1:0]          Out_Data;
    logic [SEL_W-1:0]          Out_Chan;
    logic                      Out_Valid;
    logic                      Out_Ready;

    modport master (
        output Mode, Sel, In_Data, In_Valid, Out_Ready,
        input  In_Ready, Out_Data, Out_Chan, Out_Valid
    );

    modport slave (
        input  Mode, Sel, In_Data, In_Valid, Out_Ready,
        output In_Ready, Out_Data, Out_Chan, Out_Valid
    );

endinterface

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// mux_rr_pipe_rr_arbiter
// Combinational round-robin arbiter. Searches i_req starting at i_ptr+1,
// wrapping past CHANNELS-1 to 0, and grants the first requester.
//   i_req         : request vector
//   i_ptr         : last granted channel (search starts after it)
//   o_gnt         : one-hot grant (zero when nothing requests)
//   o_gnt_idx     : index of the granted channel
//   o_gnt_valid   : a grant was made
module mux_rr_pipe_rr_arbiter
    import mux_rr_pipe_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]        i_req,
    input  logic [clog2(CHANNELS)-1:0] i_ptr,
    output logic [CHANNELS-1:0]        o_gnt,
    output logic [clog2(CHANNELS)-1:0] o_gnt_idx,
    output logic                       o_gnt_valid
);
    localparam int unsigned SEL_W = clog2(CHANNELS);

    always_comb begin
        int unsigned idx;
        logic        found;
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        found       = 1'b0;
        idx         = 0;
        // Offset CHANNELS comes back to i_ptr itself, so a lone requester
        // equal to the pointer is still granted.
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            idx = (32'(i_ptr) + off) % CHANNELS;
            if (!found && i_req[SEL_W'(idx)]) begin
                found       = 1'b1;
                o_gnt_idx   = SEL_W'(idx);
                o_gnt_valid = 1'b1;
            end
        end
        if (found) begin
            o_gnt = CHANNELS'(1) << o_gnt_idx;
        end
    end

endmodule

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe
// Registered N-channel operand multiplexer with valid/ready on every port.
// One channel is granted per cycle (fixed Sel or round-robin) and its word is
// captured in a single output register.
//   Clk    : rising-edge clock
//   Reset  : synchronous, active-high reset
//   bus    : mux_rr_pipe_if.slave (Mode/Sel, per-channel inputs, output handshake)
module mux_rr_pipe
    import mux_rr_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned CHANNELS = 4
) (
    input logic          Clk,
    input logic          Reset,
    mux_rr_pipe_if.slave bus
);
    localparam int unsigned SEL_W = clog2(CHANNELS);

    out_state_e       r_state;
    out_state_e       w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_chan;
    logic [SEL_W-1:0] r_ptr;

    logic                w_load;
    logic                w_sel_ok;
    logic [CHANNELS-1:0] w_fix_gnt;
    logic [CHANNELS-1:0] w_rr_gnt;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_rr_valid;
    logic [CHANNELS-1:0] w_gnt;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_gnt_valid;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_gnt_data;

    assign w_load = (r_state == StEmpty) || bus.Out_Ready;

    // Fixed-select path; an out-of-range Sel (non power-of-two CHANNELS) grants nothing.
    assign w_sel_ok  = (32'(bus.Sel) < CHANNELS) && bus.In_Valid[bus.Sel];
    assign w_fix_gnt = w_sel_ok ? (CHANNELS'(1) << bus.Sel) : '0;

    mux_rr_pipe_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .i_req       (bus.In_Valid),
        .i_ptr       (r_ptr),
        .o_gnt       (w_rr_gnt),
        .o_gnt_idx   (w_rr_idx),
        .o_gnt_valid (w_rr_valid)
    );

    assign w_gnt       = (bus.Mode == MODE_RR) ? w_rr_gnt   : w_fix_gnt;
    assign w_gnt_idx   = (bus.Mode == MODE_RR) ? w_rr_idx   : bus.Sel;
    assign w_gnt_valid = (bus.Mode == MODE_RR) ? w_rr_valid : w_sel_ok;

    // A grant implies the channel is valid, so ready alone decides the transfer.
    assign bus.In_Ready = w_load ? w_gnt : '0;
    assign w_xfer       = w_gnt_valid && w_load;

    always_comb begin
        w_gnt_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
                w_gnt_data = bus.In_Data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_xfer) w_state_next = StFull;
            StFull:  if (bus.Out_Ready && !w_xfer) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StEmpty;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= SEL_W'(CHANNELS - 1);
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_data <= w_gnt_data;
                r_chan <= w_gnt_idx;
                if (bus.Mode == MODE_RR) begin
                    r_ptr <= w_gnt_idx;
                end
            end
        end
    end

    assign bus.Out_Data  = r_data;
    assign bus.Out_Chan  = r_chan;
    assign bus.Out_Valid = (r_state == StFull);

endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe
// Directed bench for mux_rr_pipe with CHANNELS = 4, WIDTH = 6.
// Channel words: ch0 = 6'h11, ch1 = 6'h15, ch2 = 6'h2A, ch3 = 6'h3C.
module tb_mux_rr_pipe;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    mux_rr_pipe_if #(.WIDTH(6), .CHANNELS(4)) bus ();

    mux_rr_pipe #(
        .WIDTH    (6),
        .CHANNELS (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [5:0] d,
                             input logic [1:0] c);
        check({tag, ".valid"}, 32'(bus.Out_Valid), 32'(v));
        check({tag, ".data"},  32'(bus.Out_Data),  32'(d));
        check({tag, ".chan"},  32'(bus.Out_Chan),  32'(c));
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        logic [1:0] rr_seq2 [3];
        logic [5:0] ch_data [4];
        total = 0;
        bad   = 0;
        ch_data[0] = 6'h11;
        ch_data[1] = 6'h15;
        ch_data[2] = 6'h2A;
        ch_data[3] = 6'h3C;

        Reset         = 1'b1;
        bus.Mode      = 1'b0;
        bus.Sel       = 2'd0;
        bus.In_Data   = {6'h3C, 6'h2A, 6'h15, 6'h11};
        bus.In_Valid  = 4'b0000;
        bus.Out_Ready = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_out("reset", 1'b0, 6'h00, 2'd0);

        // Fixed select on channel 2
        bus.Sel      = 2'd2;
        bus.In_Valid = 4'b0100;
        #1;
        check("fix2.ready", 32'(bus.In_Ready), 32'h4);
        tick();
        check_out("fix2", 1'b1, 6'h2A, 2'd2);
        check("fix2.ready_after", 32'(bus.In_Ready), 32'h4);

        // Fixed select on an idle channel: others ignored, output drains
        bus.Sel      = 2'd1;
        bus.In_Valid = 4'b1101;
        #1;
        check("fix1.ready", 32'(bus.In_Ready), 32'h0);
        tick();
        check_out("fix1.drain", 1'b0, 6'h2A, 2'd2);

        // Round-robin from reset, all valid: 0,1,2,3,0
        Reset = 1'b1;
        tick();
        Reset        = 1'b0;
        bus.Mode     = 1'b1;
        bus.In_Valid = 4'b1111;
        #1;
        check("rr.first_ready", 32'(bus.In_Ready), 32'h1);
        rr_seq[0] = 2'd0;
        rr_seq[1] = 2'd1;
        rr_seq[2] = 2'd2;
        rr_seq[3] = 2'd3;
        rr_seq[4] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("rr.seq%0d", i), 1'b1, ch_data[rr_seq[i]], rr_seq[i]);
        end

        // Backpressure with 1010 valid: output frozen, no ready
        bus.In_Valid  = 4'b1010;
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d.ready", i), 32'(bus.In_Ready), 32'h0);
            tick();
            check_out($sformatf("stall%0d", i), 1'b1, 6'h11, 2'd0);
        end
        bus.Out_Ready = 1'b1;
        #1;
        check("release.ready", 32'(bus.In_Ready), 32'h2);
        rr_seq2[0] = 2'd1;
        rr_seq2[1] = 2'd3;
        rr_seq2[2] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("release%0d", i), 1'b1, ch_data[rr_seq2[i]], rr_seq2[i]);
        end

        // Reset while a word is held: word discarded, pointer back to CHANNELS-1
        bus.In_Valid = 4'b1111;
        Reset        = 1'b1;
        tick();
        check_out("midreset", 1'b0, 6'h00, 2'd0);
        Reset = 1'b0;
        #1;
        check("midreset.ready", 32'(bus.In_Ready), 32'h1);
        tick();
        check_out("postreset", 1'b1, 6'h11, 2'd0);

        // Pointer to 1, then two fixed transfers on Sel=3, then back to round-robin
        tick();
        check_out("ptr1", 1'b1, 6'h15, 2'd1);
        bus.Mode = 1'b0;
        bus.Sel  = 2'd3;
        #1;
        check("fix3.ready", 32'(bus.In_Ready), 32'h8);
        tick();
        check_out("fix3a", 1'b1, 6'h3C, 2'd3);
        tick();
        check_out("fix3b", 1'b1, 6'h3C, 2'd3);
        bus.Mode = 1'b1;
        #1;
        check("back_rr.ready", 32'(bus.In_Ready), 32'h4);
        tick();
        check_out("back_rr", 1'b1, 6'h2A, 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
